id_ex_alu_ctrl: RTL and testbench

Decode-side producer for the execute-stage ALU.
- Decodes the MIPS instruction word held in decode into ALU operation code, operand-select and writeback/memory control.
- Registers the result together with the register-file operands into the ID/EX pipeline register.
- Supports stall (hold), flush (bubble insertion) and a sticky illegal-instruction flag.
- Its outputs drive the execute stage: the operand muxes, the ALU op input and downstream control.

---
 rtl/id_ex_alu_ctrl_pkg.sv | 54 +++++
 rtl/id_ex_alu_ctrl_alu_decoder.sv | 79 +++++++
 rtl/id_ex_alu_ctrl.sv | 136 +++++++++++++
 tb/tb_id_ex_alu_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_alu_ctrl_pkg.sv
// Shared CPU definitions: datapath widths, ALU op codes, MIPS opcode/funct
// encodings and the control bundle carried from decode into execute.
package id_ex_alu_ctrl_pkg;

    localparam int PC_BITS       = 32;
    localparam int REG_ADDR_BITS = 5;
    localparam int IMM_BITS      = 16;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_MUL = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [5:0] OP_RTYPE    = 6'h00;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
    localparam logic [5:0] OP_LW       = 6'h23;
    localparam logic [5:0] OP_SW       = 6'h2B;
    localparam logic [5:0] OP_ADDI     = 6'h08;
    localparam logic [5:0] OP_BEQ      = 6'h04;
    localparam logic [5:0] OP_J        = 6'h02;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;
    localparam logic [5:0] FUNCT_MUL = 6'h02;

    typedef struct packed {
        logic [3:0] alu_control;
        logic       alu_src;
        logic       reg_dst;
        logic       reg_write;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic       jump;
    } ctrl_t;

    // A bubble has no side effects; the ALU code still reads as ADD.
    function automatic ctrl_t bubble_ctrl();
        ctrl_t c;
        c             = '0;
        c.alu_control = ALU_ADD;
        return c;
    endfunction

    function automatic logic [PC_BITS-1:0] sign_extend_imm(input logic [IMM_BITS-1:0] imm);
        return {{(PC_BITS-IMM_BITS){imm[IMM_BITS-1]}}, imm};
    endfunction

endpackage

// File: rtl/id_ex_alu_ctrl_alu_decoder.sv
// Purely combinational main/ALU decoder: opcode and funct to the control
// bundle plus an illegal flag. Shared with the hazard unit.
module alu_decoder
    import id_ex_alu_ctrl_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output ctrl_t      ctrl_o,
    output logic       illegal_o
);

    ctrl_t ctrlRaw;
    logic  illegalRaw;

    always_comb begin
        ctrlRaw    = '0;
        illegalRaw = 1'b0;
        case (op_i)
            OP_RTYPE: begin
                ctrlRaw.reg_dst   = 1'b1;
                ctrlRaw.reg_write = 1'b1;
                case (funct_i)
                    FUNCT_ADD: ctrlRaw.alu_control = ALU_ADD;
                    FUNCT_SUB: ctrlRaw.alu_control = ALU_SUB;
                    FUNCT_AND: ctrlRaw.alu_control = ALU_AND;
                    FUNCT_OR:  ctrlRaw.alu_control = ALU_OR;
                    FUNCT_SLT: ctrlRaw.alu_control = ALU_SLT;
                    default:   illegalRaw          = 1'b1;
                endcase
            end
            OP_SPECIAL2: begin
                ctrlRaw.reg_dst   = 1'b1;
                ctrlRaw.reg_write = 1'b1;
                if (funct_i == FUNCT_MUL) begin
                    ctrlRaw.alu_control = ALU_MUL;
                end else begin
                    illegalRaw = 1'b1;
                end
            end
            OP_LW: begin
                ctrlRaw.alu_control = ALU_ADD;
                ctrlRaw.alu_src     = 1'b1;
                ctrlRaw.reg_write   = 1'b1;
                ctrlRaw.mem_to_reg  = 1'b1;
            end
            OP_SW: begin
                ctrlRaw.alu_control = ALU_ADD;
                ctrlRaw.alu_src     = 1'b1;
                ctrlRaw.mem_write   = 1'b1;
            end
            OP_ADDI: begin
                ctrlRaw.alu_control = ALU_ADD;
                ctrlRaw.alu_src     = 1'b1;
                ctrlRaw.reg_write   = 1'b1;
            end
            OP_BEQ: begin
                ctrlRaw.alu_control = ALU_SUB;
                ctrlRaw.branch      = 1'b1;
            end
            // Jump carries no ALU work, so its op code stays at all-zero.
            OP_J: begin
                ctrlRaw.jump = 1'b1;
            end
            default: begin
                illegalRaw = 1'b1;
            end
        endcase
    end

    // Unsupported encodings must never leak partial control to consumers.
    always_comb begin
        ctrl_o    = ctrlRaw;
        illegal_o = illegalRaw;
        if (illegalRaw) begin
            ctrl_o = bubble_ctrl();
        end
    end

endmodule

// File: rtl/id_ex_alu_ctrl.sv
// ID/EX pipeline register for the ALU path: decodes the instruction in
// decode and captures control, operands and specifiers for execute.
module id_ex_alu_ctrl
    import id_ex_alu_ctrl_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              instr_d,
    input  logic                     valid_d,
    input  logic [PC_BITS-1:0]       rd1_d,
    input  logic [PC_BITS-1:0]       rd2_d,
    input  logic                     stall_e,
    input  logic                     flush_e,
    output logic                     valid_e,
    output logic [3:0]               alu_control_e,
    output logic                     alu_src_e,
    output logic                     reg_dst_e,
    output logic                     reg_write_e,
    output logic                     mem_write_e,
    output logic                     mem_to_reg_e,
    output logic                     branch_e,
    output logic                     jump_e,
    output logic [PC_BITS-1:0]       rd1_e,
    output logic [PC_BITS-1:0]       rd2_e,
    output logic [PC_BITS-1:0]       imm_e,
    output logic [REG_ADDR_BITS-1:0] rs_e,
    output logic [REG_ADDR_BITS-1:0] rt_e,
    output logic [REG_ADDR_BITS-1:0] rd_e,
    output logic                     illegal_e
);

    ctrl_t decCtrl;
    logic  decIllegal;

    alu_decoder u_alu_decoder (
        .op_i      (instr_d[31:26]),
        .funct_i   (instr_d[5:0]),
        .ctrl_o    (decCtrl),
        .illegal_o (decIllegal)
    );

    logic                     validEx_q,   validEx_d;
    ctrl_t                    ctrlEx_q,    ctrlEx_d;
    logic [PC_BITS-1:0]       rd1Ex_q,     rd1Ex_d;
    logic [PC_BITS-1:0]       rd2Ex_q,     rd2Ex_d;
    logic [PC_BITS-1:0]       immEx_q,     immEx_d;
    logic [REG_ADDR_BITS-1:0] rsEx_q,      rsEx_d;
    logic [REG_ADDR_BITS-1:0] rtEx_q,      rtEx_d;
    logic [REG_ADDR_BITS-1:0] rdEx_q,      rdEx_d;
    logic                     illegalEx_q, illegalEx_d;

    logic holdSlot;
    logic advance;
    logic takeNew;

    // Flush outranks stall; the decode word only advances when neither is set.
    assign holdSlot = stall_e && !flush_e;
    assign advance  = !stall_e && !flush_e;
    assign takeNew  = advance && valid_d && !decIllegal;

    always_comb begin
        validEx_d = 1'b0;
        ctrlEx_d  = bubble_ctrl();
        rd1Ex_d   = '0;
        rd2Ex_d   = '0;
        immEx_d   = '0;
        rsEx_d    = '0;
        rtEx_d    = '0;
        rdEx_d    = '0;
        if (holdSlot) begin
            validEx_d = validEx_q;
            ctrlEx_d  = ctrlEx_q;
            rd1Ex_d   = rd1Ex_q;
            rd2Ex_d   = rd2Ex_q;
            immEx_d   = immEx_q;
            rsEx_d    = rsEx_q;
            rtEx_d    = rtEx_q;
            rdEx_d    = rdEx_q;
        end else if (takeNew) begin
            validEx_d = 1'b1;
            ctrlEx_d  = decCtrl;
            rd1Ex_d   = rd1_d;
            rd2Ex_d   = rd2_d;
            immEx_d   = sign_extend_imm(instr_d[15:0]);
            rsEx_d    = instr_d[25:21];
            rtEx_d    = instr_d[20:16];
            rdEx_d    = instr_d[15:11];
        end
    end

    // Illegal is latched when the offending word actually leaves decode,
    // so a stalled illegal word is flagged once it advances.
    assign illegalEx_d = illegalEx_q | (advance & valid_d & decIllegal);

    always_ff @(posedge clk) begin
        if (reset) begin
            validEx_q   <= 1'b0;
            ctrlEx_q    <= bubble_ctrl();
            rd1Ex_q     <= '0;
            rd2Ex_q     <= '0;
            immEx_q     <= '0;
            rsEx_q      <= '0;
            rtEx_q      <= '0;
            rdEx_q      <= '0;
            illegalEx_q <= 1'b0;
        end else begin
            validEx_q   <= validEx_d;
            ctrlEx_q    <= ctrlEx_d;
            rd1Ex_q     <= rd1Ex_d;
            rd2Ex_q     <= rd2Ex_d;
            immEx_q     <= immEx_d;
            rsEx_q      <= rsEx_d;
            rtEx_q      <= rtEx_d;
            rdEx_q      <= rdEx_d;
            illegalEx_q <= illegalEx_d;
        end
    end

    assign valid_e       = validEx_q;
    assign alu_control_e = ctrlEx_q.alu_control;
    assign alu_src_e     = ctrlEx_q.alu_src;
    assign reg_dst_e     = ctrlEx_q.reg_dst;
    assign reg_write_e   = ctrlEx_q.reg_write;
    assign mem_write_e   = ctrlEx_q.mem_write;
    assign mem_to_reg_e  = ctrlEx_q.mem_to_reg;
    assign branch_e      = ctrlEx_q.branch;
    assign jump_e        = ctrlEx_q.jump;
    assign rd1_e         = rd1Ex_q;
    assign rd2_e         = rd2Ex_q;
    assign imm_e         = immEx_q;
    assign rs_e          = rsEx_q;
    assign rt_e          = rtEx_q;
    assign rd_e          = rdEx_q;
    assign illegal_e     = illegalEx_q;

endmodule

// File: tb/tb_id_ex_alu_ctrl.sv
// Directed bench for the ID/EX ALU control register: a decode table plus
// hand-written reset, stall/flush and illegal-instruction sequences.
module tb_id_ex_alu_ctrl;
    import id_ex_alu_ctrl_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] instr_d;
    logic        valid_d;
    logic [31:0] rd1_d;
    logic [31:0] rd2_d;
    logic        stall_e;
    logic        flush_e;
    logic        valid_e;
    logic [3:0]  alu_control_e;
    logic        alu_src_e;
    logic        reg_dst_e;
    logic        reg_write_e;
    logic        mem_write_e;
    logic        mem_to_reg_e;
    logic        branch_e;
    logic        jump_e;
    logic [31:0] rd1_e;
    logic [31:0] rd2_e;
    logic [31:0] imm_e;
    logic [4:0]  rs_e;
    logic [4:0]  rt_e;
    logic [4:0]  rd_e;
    logic        illegal_e;

    int checks;
    int failures;

    id_ex_alu_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .instr_d       (instr_d),
        .valid_d       (valid_d),
        .rd1_d         (rd1_d),
        .rd2_d         (rd2_d),
        .stall_e       (stall_e),
        .flush_e       (flush_e),
        .valid_e       (valid_e),
        .alu_control_e (alu_control_e),
        .alu_src_e     (alu_src_e),
        .reg_dst_e     (reg_dst_e),
        .reg_write_e   (reg_write_e),
        .mem_write_e   (mem_write_e),
        .mem_to_reg_e  (mem_to_reg_e),
        .branch_e      (branch_e),
        .jump_e        (jump_e),
        .rd1_e         (rd1_e),
        .rd2_e         (rd2_e),
        .imm_e         (imm_e),
        .rs_e          (rs_e),
        .rt_e          (rt_e),
        .rd_e          (rd_e),
        .illegal_e     (illegal_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [3:0]  alu;
        logic        src, dst, rw, mw, m2r, br, j;
        logic [31:0] rd1, rd2, imm;
        logic [4:0]  rs, rt, rd;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic        valid;
        logic [31:0] rd1, rd2;
        exp_t        e;
    } vec_t;

    function automatic exp_t expOf(input logic v, input logic [3:0] alu,
                                   input logic src, dst, rw, mw, m2r, br, j,
                                   input logic [31:0] r1, r2, imm,
                                   input logic [4:0] rs, rt, rd, input logic ill);
        exp_t e;
        e.valid = v;  e.alu = alu;
        e.src = src;  e.dst = dst; e.rw = rw; e.mw = mw; e.m2r = m2r; e.br = br; e.j = j;
        e.rd1 = r1;   e.rd2 = r2;  e.imm = imm;
        e.rs = rs;    e.rt = rt;   e.rd = rd;  e.ill = ill;
        return e;
    endfunction

    function automatic exp_t bubbleExp(input logic ill);
        return expOf(1'b0, ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, ill);
    endfunction

    task automatic checkField(input string tag, input string field,
                              input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s.%s: got %h, expected %h", tag, field, act, exp);
        end
    endtask

    // Compares every ID/EX output against the hand-computed expectation.
    task automatic checkOutput(input string tag, input exp_t e);
        checkField(tag, "valid_e",       32'(valid_e),       32'(e.valid));
        checkField(tag, "alu_control_e", 32'(alu_control_e), 32'(e.alu));
        checkField(tag, "alu_src_e",     32'(alu_src_e),     32'(e.src));
        checkField(tag, "reg_dst_e",     32'(reg_dst_e),     32'(e.dst));
        checkField(tag, "reg_write_e",   32'(reg_write_e),   32'(e.rw));
        checkField(tag, "mem_write_e",   32'(mem_write_e),   32'(e.mw));
        checkField(tag, "mem_to_reg_e",  32'(mem_to_reg_e),  32'(e.m2r));
        checkField(tag, "branch_e",      32'(branch_e),      32'(e.br));
        checkField(tag, "jump_e",        32'(jump_e),        32'(e.j));
        checkField(tag, "rd1_e",         rd1_e,              e.rd1);
        checkField(tag, "rd2_e",         rd2_e,              e.rd2);
        checkField(tag, "imm_e",         imm_e,              e.imm);
        checkField(tag, "rs_e",          32'(rs_e),          32'(e.rs));
        checkField(tag, "rt_e",          32'(rt_e),          32'(e.rt));
        checkField(tag, "rd_e",          32'(rd_e),          32'(e.rd));
        checkField(tag, "illegal_e",     32'(illegal_e),     32'(e.ill));
    endtask

    // Drives one cycle of decode-side inputs and settles just past the edge.
    task automatic applyStimulus(input logic [31:0] instr, input logic v,
                                 input logic [31:0] r1, r2, input logic st, fl);
        instr_d = instr;
        valid_d = v;
        rd1_d   = r1;
        rd2_d   = r2;
        stall_e = st;
        flush_e = fl;
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] I_ADD  = 32'h0022_1820;
    localparam logic [31:0] I_LW   = 32'h8C22_FFFC;
    localparam logic [31:0] I_MUL  = 32'h7022_1802;
    localparam logic [31:0] I_SUB  = 32'h0022_1822;
    localparam logic [31:0] I_SW   = 32'hAC22_0008;
    localparam logic [31:0] I_BAD  = 32'hFC00_0000;
    localparam logic [31:0] I_ADDU = 32'h0000_0021;

    vec_t vecs[13];
    exp_t eAdd;
    exp_t eSub;
    exp_t eMul;

    initial begin
        checks   = 0;
        failures = 0;

        vecs[0]  = '{I_ADD,        1'b1, 32'h5,        32'h7,        expOf(1, ALU_ADD, 0,1,1,0,0,0,0, 32'h5,        32'h7,        32'h0000_1820, 5'd1,  5'd2,  5'd3,  0)};
        vecs[1]  = '{I_LW,         1'b1, 32'h11,       32'h22,       expOf(1, ALU_ADD, 1,0,1,0,1,0,0, 32'h11,       32'h22,       32'hFFFF_FFFC, 5'd1,  5'd2,  5'd31, 0)};
        vecs[2]  = '{I_MUL,        1'b1, 32'h3,        32'h4,        expOf(1, ALU_MUL, 0,1,1,0,0,0,0, 32'h3,        32'h4,        32'h0000_1802, 5'd1,  5'd2,  5'd3,  0)};
        vecs[3]  = '{I_SUB,        1'b1, 32'hA,        32'hB,        expOf(1, ALU_SUB, 0,1,1,0,0,0,0, 32'hA,        32'hB,        32'h0000_1822, 5'd1,  5'd2,  5'd3,  0)};
        vecs[4]  = '{32'h0022_1824, 1'b1, 32'hFFFF_0000, 32'h0F0F_0F0F, expOf(1, ALU_AND, 0,1,1,0,0,0,0, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0000_1824, 5'd1,  5'd2,  5'd3,  0)};
        vecs[5]  = '{32'h0022_1825, 1'b1, 32'h1234_5678, 32'h8765_4321, expOf(1, ALU_OR,  0,1,1,0,0,0,0, 32'h1234_5678, 32'h8765_4321, 32'h0000_1825, 5'd1,  5'd2,  5'd3,  0)};
        vecs[6]  = '{32'h0022_182A, 1'b1, 32'h20,       32'h21,       expOf(1, ALU_SLT, 0,1,1,0,0,0,0, 32'h20,       32'h21,       32'h0000_182A, 5'd1,  5'd2,  5'd3,  0)};
        vecs[7]  = '{I_SW,         1'b1, 32'h40,       32'h41,       expOf(1, ALU_ADD, 1,0,0,1,0,0,0, 32'h40,       32'h41,       32'h0000_0008, 5'd1,  5'd2,  5'd0,  0)};
        vecs[8]  = '{32'h2022_FFFF, 1'b1, 32'h50,       32'h51,       expOf(1, ALU_ADD, 1,0,1,0,0,0,0, 32'h50,       32'h51,       32'hFFFF_FFFF, 5'd1,  5'd2,  5'd31, 0)};
        vecs[9]  = '{32'h1022_0004, 1'b1, 32'h60,       32'h61,       expOf(1, ALU_SUB, 0,0,0,0,0,1,0, 32'h60,       32'h61,       32'h0000_0004, 5'd1,  5'd2,  5'd0,  0)};
        vecs[10] = '{32'h0800_0010, 1'b1, 32'h70,       32'h71,       expOf(1, ALU_AND, 0,0,0,0,0,0,1, 32'h70,       32'h71,       32'h0000_0010, 5'd0,  5'd0,  5'd0,  0)};
        vecs[11] = '{32'h014B_4820, 1'b1, 32'h80,       32'h81,       expOf(1, ALU_ADD, 0,1,1,0,0,0,0, 32'h80,       32'h81,       32'h0000_4820, 5'd10, 5'd11, 5'd9,  0)};
        vecs[12] = '{I_ADD,        1'b0, 32'h90,       32'h91,       bubbleExp(0)};

        eAdd = vecs[0].e;
        eSub = vecs[3].e;
        eMul = vecs[2].e;

        // Reset held two cycles with a live instruction on the inputs.
        reset = 1'b1;
        applyStimulus(I_ADD, 1'b1, 32'h5, 32'h7, 1'b0, 1'b0);
        applyStimulus(I_ADD, 1'b1, 32'h5, 32'h7, 1'b0, 1'b0);
        checkOutput("reset", bubbleExp(0));
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].instr, vecs[i].valid, vecs[i].rd1, vecs[i].rd2, 1'b0, 1'b0);
            checkOutput($sformatf("vec%0d", i), vecs[i].e);
        end

        // Stall holds the add while decode moves on to a store.
        applyStimulus(I_ADD, 1'b1, 32'h5, 32'h7, 1'b0, 1'b0);
        checkOutput("stall_load", eAdd);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(I_SW, 1'b1, 32'h99, 32'h98, 1'b1, 1'b0);
            checkOutput($sformatf("stall_hold%0d", i), eAdd);
        end
        applyStimulus(I_SW, 1'b1, 32'h99, 32'h98, 1'b1, 1'b1);
        checkOutput("flush_over_stall", bubbleExp(0));

        // A stalled instruction emerges intact and the next one follows once.
        applyStimulus(I_SUB, 1'b1, 32'hA, 32'hB, 1'b0, 1'b0);
        checkOutput("emerge_load", eSub);
        applyStimulus(I_MUL, 1'b1, 32'h3, 32'h4, 1'b1, 1'b0);
        checkOutput("emerge_hold0", eSub);
        applyStimulus(I_MUL, 1'b1, 32'h3, 32'h4, 1'b1, 1'b0);
        checkOutput("emerge_hold1", eSub);
        applyStimulus(I_MUL, 1'b1, 32'h3, 32'h4, 1'b0, 1'b0);
        checkOutput("emerge_next", eMul);
        applyStimulus(I_ADD, 1'b1, 32'h5, 32'h7, 1'b0, 1'b1);
        checkOutput("flush_only", bubbleExp(0));

        // Illegal opcode loads a bubble and sets the sticky flag.
        applyStimulus(I_BAD, 1'b1, 32'h1, 32'h2, 1'b0, 1'b0);
        checkOutput("illegal_op", bubbleExp(1));
        applyStimulus(I_ADD, 1'b1, 32'h5, 32'h7, 1'b0, 1'b0);
        checkOutput("illegal_sticky_add", expOf(1, ALU_ADD, 0,1,1,0,0,0,0, 32'h5, 32'h7, 32'h0000_1820, 5'd1, 5'd2, 5'd3, 1));
        applyStimulus(I_LW, 1'b1, 32'h11, 32'h22, 1'b0, 1'b0);
        checkOutput("illegal_sticky_lw", expOf(1, ALU_ADD, 1,0,1,0,1,0,0, 32'h11, 32'h22, 32'hFFFF_FFFC, 5'd1, 5'd2, 5'd31, 1));

        reset = 1'b1;
        applyStimulus(I_ADD, 1'b1, 32'h5, 32'h7, 1'b0, 1'b0);
        checkOutput("illegal_reset", bubbleExp(0));
        reset = 1'b0;

        applyStimulus(I_BAD, 1'b0, 32'h1, 32'h2, 1'b0, 1'b0);
        checkOutput("illegal_invalid", bubbleExp(0));
        applyStimulus(I_ADD, 1'b1, 32'h5, 32'h7, 1'b0, 1'b0);
        checkOutput("illegal_invalid_after", eAdd);

        // Unlisted R-type funct is illegal too.
        applyStimulus(I_ADDU, 1'b1, 32'h1, 32'h2, 1'b0, 1'b0);
        checkOutput("illegal_funct", bubbleExp(1));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
